fgd_mask_gen: RTL and testbench
===============================

# fgd_mask_gen

Per-pixel foreground detector sitting directly downstream of the ambient-light threshold stage. It consumes the same paired DVI/CCD RGB565 pixel stream, plus the per-frame ambient shift and mean threshold that stage publishes. Each pixel's colour difference is compensated by the ambient shift, its squared distance is compared against the threshold, and the block emits a 1-bit foreground mask with sync coordinates. It also reports a per-frame count of foreground pixels to the overlay/control logic.

## Interface
- FRAME_W, 640, active pixels per line; last pixel is syncX = FRAME_W-1
- FRAME_H, 480, active lines per frame; last line is syncY = FRAME_H-1
- clk_pixl  in  1  pixel clock; all logic is on its rising edge
- reset  in  1  asynchronous, active-low reset
- valid_i  in  1  pixel qualifier
- syncX_i, syncY_i  in  10 each  pixel coordinates
- DVI_R_i, DVI_B_i / DVI_G_i  in  5 / 6  display pixel
- CCD_R_i, CCD_B_i / CCD_G_i  in  5 / 6  camera pixel
- AMB_SHIFT_R_i, AMB_SHIFT_G_i, AMB_SHIFT_B_i  in  8 each  ambient shift from the threshold stage, ×4 scaled
- thresh_i  in  32  mean FD² threshold from the threshold stage
- valid_o  out  1  output pixel qualifier
- syncX_o, syncY_o  out  10 each  coordinates aligned with mask_o
- mask_o  out  1  1 = foreground
- fd2_o  out  14  compensated FD² of the pixel
- hit_cnt_o  out  19  foreground pixel count of the last complete frame
- frame_done_o  out  1  one-cycle pulse when hit_cnt_o updates
- err_o  out  1  sticky; an out-of-range coordinate was seen

## Operation
- Widening: R and B are extended to 6 bits as {x,1'b0}; G is used as-is.
- Per channel:
  - del = |DVI − CCD| (6 bit).
  - amb = AMB_SHIFT_x[7:2].
  - cdel = (del > amb) ? del − amb : 0, i.e. saturating at 0.
- fd2 = cdel_R² + cdel_G² + cdel_B². The maximum is 11907, so 14 bits never overflow.
- mask = (fd2 > thresh_i_latched), as an unsigned 32-bit compare.
- FSM states:
  - WAIT_SOF (reset state): pixels are dropped and valid_o stays 0. Move to RUN on valid_i with syncX_i = 0 and syncY_i = 0.
  - RUN: every valid pixel enters the pipeline.
  - Out-of-range pixel: a valid pixel with syncX_i ≥ FRAME_W or syncY_i ≥ FRAME_H sets err_o, is dropped, and sends the FSM to WAIT_SOF.
- Parameter shadowing: AMB_SHIFT_*_i and thresh_i are latched on every accepted valid (0,0) pixel, including the WAIT_SOF→RUN transition. They are constant for the rest of that frame, so end-of-frame updates from the threshold stage apply from the next frame only.
- Frame accumulation (at the output stage):
  - The accumulator adds mask_o for each valid output pixel.
  - On the valid output pixel at (FRAME_W−1, FRAME_H−1): hit_cnt_o ← acc + mask, acc ← 0, frame_done_o = 1 for one cycle.
- Simultaneous events: the end of frame N at the output and the start of frame N+1 at the input are independent and both take effect.
- Reset mid-frame clears the pipeline, the accumulator and the FSM. No partial frame is ever counted.

## Timing
- Pipeline of 4 stages:
  1. Input register.
  2. Compensated abs diff.
  3. Squares.
  4. Sum, compare, output registers.
- valid_o, mask_o, fd2_o and syncX_o/syncY_o appear exactly 4 cycles after the accepting valid_i edge.
- Bubbles (valid_i = 0) propagate as valid_o = 0. While valid_o = 0, mask_o, fd2_o and sync_o hold their last values.
- No backpressure; the block accepts one pixel per clock.
- frame_done_o and the hit_cnt_o update coincide with the valid_o of the last pixel.
- Reset values:
  - All outputs are 0.
  - All pipeline registers, the shadow registers and the accumulator are 0.
  - The FSM is in WAIT_SOF.

## Configuration
- FGD_HITCNT_EN defined: the frame accumulator, hit_cnt_o and frame_done_o are implemented as described.
- FGD_HITCNT_EN undefined: the accumulator is removed, and hit_cnt_o and frame_done_o are tied to 0. The mask pipeline is unchanged.

## Structure
- Shared package fgd_pkg holds:
  - the FSM state typedef (WAIT_SOF, RUN);
  - the width constants PIX_W = 6, FD2_W = 14, CNT_W = 19;
  - default frame dimensions matching the threshold stage.
- Sub-module fgd_chan_diff is instantiated three times. It takes one 6-bit DVI value, one 6-bit CCD value and one 8-bit shift, and returns the registered cdel (stage 2).

## Test plan
- Reset released, first valid pixel at (5,0) → valid_o stays 0 until a (0,0) pixel, whose output arrives 4 cycles later.
- DVI = CCD = (10,20,10), AMB = 0, thresh = 0 → fd2_o = 0, mask_o = 0.
- DVI_G = 40, CCD_G = 0, other channels equal, AMB_SHIFT_G = 8'd40 (amb = 10), thresh = 899 → fd2_o = 900, mask_o = 1. With thresh = 900 → mask_o = 0.
- DVI_R = 3, CCD_R = 0 (del = 6), AMB_SHIFT_R = 8'd100 (amb = 25) → cdel saturates to 0, fd2_o = 0.
- Full 640×480 frame with exactly 1000 pixels over threshold → frame_done_o pulses once on the output pixel (639,479), hit_cnt_o = 1000. The next frame starts counting from 0.
- Valid pixel at syncX = 700 mid-frame → err_o = 1 and stays sticky, output is suppressed until the next (0,0), and hit_cnt_o is not updated for the broken frame.

Source files
------------

// File: rtl/fgd_pkg.sv
// fgd_pkg: shared types and constants for the foreground mask generator.
package fgd_pkg;

  typedef enum logic [0:0] {
    WAIT_SOF = 1'b0,
    RUN      = 1'b1
  } fgd_state_e;

  localparam int PIX_W       = 6;
  localparam int FD2_W       = 14;
  localparam int CNT_W       = 19;
  localparam int AMB_W       = 8;
  localparam int THR_W       = 32;
  localparam int COORD_W     = 10;
  localparam int DEF_FRAME_W = 640;
  localparam int DEF_FRAME_H = 480;

  // 5-bit R/B components are brought onto the 6-bit G scale
  function automatic logic [PIX_W-1:0] widen5(input logic [PIX_W-2:0] v);
    return {v, 1'b0};
  endfunction

endpackage

// File: rtl/fgd_chan_diff.sv
// fgd_chan_diff: one colour channel, |DVI - CCD| minus the ambient shift,
// saturating at zero, registered (pipeline stage 2).
module fgd_chan_diff
  import fgd_pkg::*;
(
  input  logic             clk_pixl,
  input  logic             reset,
  input  logic [PIX_W-1:0] dvi,
  input  logic [PIX_W-1:0] ccd,
  input  logic [AMB_W-1:0] shift,
  output logic [PIX_W-1:0] cdel
);

  logic [PIX_W-1:0] del_s;
  logic [PIX_W-1:0] amb_s;
  logic [PIX_W-1:0] cdel_s;
  // shift is x4 scaled; its two fraction bits are intentionally discarded
  logic             unused_frac_s;

  assign unused_frac_s = ^shift[1:0];

  // Absolute difference, then ambient compensation clamped at zero
  always_comb begin
    del_s  = {PIX_W{1'b0}};
    amb_s  = shift[AMB_W-1:2];
    cdel_s = {PIX_W{1'b0}};
    if (dvi >= ccd) begin
      del_s = dvi - ccd;
    end else begin
      del_s = ccd - dvi;
    end
    if (del_s > amb_s) begin
      cdel_s = del_s - amb_s;
    end else begin
      cdel_s = {PIX_W{1'b0}};
    end
  end

  // Stage-2 register of the compensated difference
  always_ff @(posedge clk_pixl or negedge reset) begin
    if (!reset) begin
      cdel <= {PIX_W{1'b0}};
    end else begin
      cdel <= cdel_s;
    end
  end

endmodule

// File: rtl/fgd_mask_gen.sv
// fgd_mask_gen: per-pixel foreground mask from ambient-compensated FD^2.
// Optional frame hit counter is built only when FGD_HITCNT_EN is defined;
// otherwise hit_cnt_o and frame_done_o are tied to zero.
module fgd_mask_gen
  import fgd_pkg::*;
#(
  parameter int FRAME_W = DEF_FRAME_W,
  parameter int FRAME_H = DEF_FRAME_H
) (
  input  logic               clk_pixl,
  input  logic               reset,
  input  logic               valid_i,
  input  logic [COORD_W-1:0] syncX_i,
  input  logic [COORD_W-1:0] syncY_i,
  input  logic [PIX_W-2:0]   DVI_R_i,
  input  logic [PIX_W-1:0]   DVI_G_i,
  input  logic [PIX_W-2:0]   DVI_B_i,
  input  logic [PIX_W-2:0]   CCD_R_i,
  input  logic [PIX_W-1:0]   CCD_G_i,
  input  logic [PIX_W-2:0]   CCD_B_i,
  input  logic [AMB_W-1:0]   AMB_SHIFT_R_i,
  input  logic [AMB_W-1:0]   AMB_SHIFT_G_i,
  input  logic [AMB_W-1:0]   AMB_SHIFT_B_i,
  input  logic [THR_W-1:0]   thresh_i,
  output logic               valid_o,
  output logic [COORD_W-1:0] syncX_o,
  output logic [COORD_W-1:0] syncY_o,
  output logic               mask_o,
  output logic [FD2_W-1:0]   fd2_o,
  output logic [CNT_W-1:0]   hit_cnt_o,
  output logic               frame_done_o,
  output logic               err_o
);

  localparam logic [COORD_W-1:0] LAST_X = COORD_W'(FRAME_W - 1);
  localparam logic [COORD_W-1:0] LAST_Y = COORD_W'(FRAME_H - 1);
  localparam logic [COORD_W-1:0] ZERO_C = {COORD_W{1'b0}};

  fgd_state_e state_r, state_nxt_s;
  logic oor_s, sof_s, accept_s, latch_s;

  logic [AMB_W-1:0] amb_red_r, amb_grn_r, amb_blu_r;
  logic [THR_W-1:0] thr_sh_r;

  logic               s1_valid_r, s2_valid_r, s3_valid_r, s4_valid_r;
  logic [COORD_W-1:0] s1_x_r, s2_x_r, s3_x_r, s4_x_r;
  logic [COORD_W-1:0] s1_y_r, s2_y_r, s3_y_r, s4_y_r;
  logic [THR_W-1:0]   s1_thr_r, s2_thr_r, s3_thr_r, s4_thr_r;
  logic [PIX_W-1:0]   s1_dvi_red_r, s1_dvi_grn_r, s1_dvi_blu_r;
  logic [PIX_W-1:0]   s1_ccd_red_r, s1_ccd_grn_r, s1_ccd_blu_r;
  logic [PIX_W-1:0]   cdel_red_s, cdel_grn_s, cdel_blu_s;
  logic [2*PIX_W-1:0] sq_red_r, sq_grn_r, sq_blu_r;
  logic [FD2_W-1:0]   s4_sum_r;
  logic               mask_s;

  // Pixel classification and frame-sync FSM next state
  always_comb begin
    oor_s       = 1'b0;
    sof_s       = 1'b0;
    accept_s    = 1'b0;
    state_nxt_s = state_r;
    if (valid_i) begin
      oor_s = (syncX_i > LAST_X) || (syncY_i > LAST_Y);
      sof_s = (syncX_i == ZERO_C) && (syncY_i == ZERO_C);
    end else begin
      oor_s = 1'b0;
      sof_s = 1'b0;
    end
    case (state_r)
      WAIT_SOF: begin
        if (oor_s) begin
          state_nxt_s = WAIT_SOF;
        end else if (sof_s) begin
          state_nxt_s = RUN;
          accept_s    = 1'b1;
        end else begin
          state_nxt_s = WAIT_SOF;
        end
      end
      RUN: begin
        if (oor_s) begin
          state_nxt_s = WAIT_SOF;
        end else begin
          state_nxt_s = RUN;
          accept_s    = valid_i;
        end
      end
      default: state_nxt_s = WAIT_SOF;
    endcase
  end

  assign latch_s = accept_s & sof_s;

  // FSM state register
  always_ff @(posedge clk_pixl or negedge reset) begin
    if (!reset) state_r <= WAIT_SOF;
    else        state_r <= state_nxt_s;
  end

  // Sticky out-of-range flag
  always_ff @(posedge clk_pixl or negedge reset) begin
    if (!reset)     err_o <= 1'b0;
    else if (oor_s) err_o <= 1'b1;
    else            err_o <= err_o;
  end

  // Per-frame shadow of the threshold-stage parameters, taken at frame start
  always_ff @(posedge clk_pixl or negedge reset) begin
    if (!reset) begin
      amb_red_r <= {AMB_W{1'b0}};
      amb_grn_r <= {AMB_W{1'b0}};
      amb_blu_r <= {AMB_W{1'b0}};
      thr_sh_r  <= {THR_W{1'b0}};
    end else if (latch_s) begin
      amb_red_r <= AMB_SHIFT_R_i;
      amb_grn_r <= AMB_SHIFT_G_i;
      amb_blu_r <= AMB_SHIFT_B_i;
      thr_sh_r  <= thresh_i;
    end else begin
      thr_sh_r  <= thr_sh_r;
    end
  end

  // Stage 1: input register; the threshold travels with its pixel so a
  // new frame's threshold never applies to the previous frame's tail
  always_ff @(posedge clk_pixl or negedge reset) begin
    if (!reset) begin
      s1_valid_r   <= 1'b0;
      s1_x_r       <= ZERO_C;
      s1_y_r       <= ZERO_C;
      s1_thr_r     <= {THR_W{1'b0}};
      s1_dvi_red_r <= {PIX_W{1'b0}};
      s1_dvi_grn_r <= {PIX_W{1'b0}};
      s1_dvi_blu_r <= {PIX_W{1'b0}};
      s1_ccd_red_r <= {PIX_W{1'b0}};
      s1_ccd_grn_r <= {PIX_W{1'b0}};
      s1_ccd_blu_r <= {PIX_W{1'b0}};
    end else begin
      s1_valid_r   <= accept_s;
      s1_x_r       <= syncX_i;
      s1_y_r       <= syncY_i;
      s1_thr_r     <= latch_s ? thresh_i : thr_sh_r;
      s1_dvi_red_r <= widen5(DVI_R_i);
      s1_dvi_grn_r <= DVI_G_i;
      s1_dvi_blu_r <= widen5(DVI_B_i);
      s1_ccd_red_r <= widen5(CCD_R_i);
      s1_ccd_grn_r <= CCD_G_i;
      s1_ccd_blu_r <= widen5(CCD_B_i);
    end
  end

  fgd_chan_diff u_diff_red (.clk_pixl(clk_pixl), .reset(reset), .dvi(s1_dvi_red_r),
                            .ccd(s1_ccd_red_r), .shift(amb_red_r), .cdel(cdel_red_s));
  fgd_chan_diff u_diff_grn (.clk_pixl(clk_pixl), .reset(reset), .dvi(s1_dvi_grn_r),
                            .ccd(s1_ccd_grn_r), .shift(amb_grn_r), .cdel(cdel_grn_s));
  fgd_chan_diff u_diff_blu (.clk_pixl(clk_pixl), .reset(reset), .dvi(s1_dvi_blu_r),
                            .ccd(s1_ccd_blu_r), .shift(amb_blu_r), .cdel(cdel_blu_s));

  // Stages 2-4: sideband alignment, squares, and FD^2 sum
  always_ff @(posedge clk_pixl or negedge reset) begin
    if (!reset) begin
      {s2_valid_r, s3_valid_r, s4_valid_r} <= 3'b000;
      {s2_x_r, s3_x_r, s4_x_r}             <= {3{ZERO_C}};
      {s2_y_r, s3_y_r, s4_y_r}             <= {3{ZERO_C}};
      {s2_thr_r, s3_thr_r, s4_thr_r}       <= {3{{THR_W{1'b0}}}};
      sq_red_r                             <= {2*PIX_W{1'b0}};
      sq_grn_r                             <= {2*PIX_W{1'b0}};
      sq_blu_r                             <= {2*PIX_W{1'b0}};
      s4_sum_r                             <= {FD2_W{1'b0}};
    end else begin
      {s2_valid_r, s3_valid_r, s4_valid_r} <= {s1_valid_r, s2_valid_r, s3_valid_r};
      {s2_x_r, s3_x_r, s4_x_r}             <= {s1_x_r, s2_x_r, s3_x_r};
      {s2_y_r, s3_y_r, s4_y_r}             <= {s1_y_r, s2_y_r, s3_y_r};
      {s2_thr_r, s3_thr_r, s4_thr_r}       <= {s1_thr_r, s2_thr_r, s3_thr_r};
      sq_red_r <= {{PIX_W{1'b0}}, cdel_red_s} * {{PIX_W{1'b0}}, cdel_red_s};
      sq_grn_r <= {{PIX_W{1'b0}}, cdel_grn_s} * {{PIX_W{1'b0}}, cdel_grn_s};
      sq_blu_r <= {{PIX_W{1'b0}}, cdel_blu_s} * {{PIX_W{1'b0}}, cdel_blu_s};
      s4_sum_r <= {{(FD2_W-2*PIX_W){1'b0}}, sq_red_r}
                + {{(FD2_W-2*PIX_W){1'b0}}, sq_grn_r}
                + {{(FD2_W-2*PIX_W){1'b0}}, sq_blu_r};
    end
  end

  // Unsigned 32-bit threshold compare
  always_comb begin
    mask_s = 1'b0;
    if ({{(THR_W-FD2_W){1'b0}}, s4_sum_r} > s4_thr_r) mask_s = 1'b1;
    else                                              mask_s = 1'b0;
  end

  // Output registers; data holds across bubbles
  always_ff @(posedge clk_pixl or negedge reset) begin
    if (!reset) begin
      valid_o <= 1'b0;
      syncX_o <= ZERO_C;
      syncY_o <= ZERO_C;
      mask_o  <= 1'b0;
      fd2_o   <= {FD2_W{1'b0}};
    end else begin
      valid_o <= s4_valid_r;
      if (s4_valid_r) begin
        syncX_o <= s4_x_r;
        syncY_o <= s4_y_r;
        mask_o  <= mask_s;
        fd2_o   <= s4_sum_r;
      end else begin
        mask_o  <= mask_o;
      end
    end
  end

`ifdef FGD_HITCNT_EN
  logic [CNT_W-1:0] acc_r;
  logic [CNT_W-1:0] mask_ext_s;

  assign mask_ext_s = {{(CNT_W-1){1'b0}}, mask_s};

  // Frame hit accumulator; restarting at each output (0,0) discards any
  // partial count left by a frame aborted on an out-of-range pixel
  always_ff @(posedge clk_pixl or negedge reset) begin
    if (!reset) begin
      acc_r        <= {CNT_W{1'b0}};
      hit_cnt_o    <= {CNT_W{1'b0}};
      frame_done_o <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;
      if (s4_valid_r) begin
        if ((s4_x_r == LAST_X) && (s4_y_r == LAST_Y)) begin
          hit_cnt_o    <= acc_r + mask_ext_s;
          acc_r        <= {CNT_W{1'b0}};
          frame_done_o <= 1'b1;
        end else if ((s4_x_r == ZERO_C) && (s4_y_r == ZERO_C)) begin
          acc_r <= mask_ext_s;
        end else begin
          acc_r <= acc_r + mask_ext_s;
        end
      end else begin
        acc_r <= acc_r;
      end
    end
  end
`else
  assign hit_cnt_o    = {CNT_W{1'b0}};
  assign frame_done_o = 1'b0;
`endif

endmodule

// File: tb/tb_fgd_mask_gen.sv
// tb_fgd_mask_gen: directed + randomized bench with a behavioural reference
// model; uses a reduced frame so several whole frames fit in a short run.
module tb_fgd_mask_gen;

  localparam int W   = 16;
  localparam int H   = 4;
  localparam int LAT = 4;
`ifdef FGD_HITCNT_EN
  localparam bit HIT_EN = 1'b1;
`else
  localparam bit HIT_EN = 1'b0;
`endif

  logic        clk_pixl = 1'b0;
  logic        reset = 1'b0;
  logic        valid_i = 1'b0;
  logic [9:0]  syncX_i = 10'd0, syncY_i = 10'd0;
  logic [4:0]  DVI_R_i = 5'd0, DVI_B_i = 5'd0, CCD_R_i = 5'd0, CCD_B_i = 5'd0;
  logic [5:0]  DVI_G_i = 6'd0, CCD_G_i = 6'd0;
  logic [7:0]  AMB_SHIFT_R_i = 8'd0, AMB_SHIFT_G_i = 8'd0, AMB_SHIFT_B_i = 8'd0;
  logic [31:0] thresh_i = 32'd0;
  logic        valid_o, mask_o, frame_done_o, err_o;
  logic [9:0]  syncX_o, syncY_o;
  logic [13:0] fd2_o;
  logic [18:0] hit_cnt_o;

  fgd_mask_gen #(.FRAME_W(W), .FRAME_H(H)) dut (
    .clk_pixl(clk_pixl), .reset(reset), .valid_i(valid_i),
    .syncX_i(syncX_i), .syncY_i(syncY_i),
    .DVI_R_i(DVI_R_i), .DVI_G_i(DVI_G_i), .DVI_B_i(DVI_B_i),
    .CCD_R_i(CCD_R_i), .CCD_G_i(CCD_G_i), .CCD_B_i(CCD_B_i),
    .AMB_SHIFT_R_i(AMB_SHIFT_R_i), .AMB_SHIFT_G_i(AMB_SHIFT_G_i),
    .AMB_SHIFT_B_i(AMB_SHIFT_B_i), .thresh_i(thresh_i),
    .valid_o(valid_o), .syncX_o(syncX_o), .syncY_o(syncY_o),
    .mask_o(mask_o), .fd2_o(fd2_o), .hit_cnt_o(hit_cnt_o),
    .frame_done_o(frame_done_o), .err_o(err_o)
  );

  always #5 clk_pixl = ~clk_pixl;

  typedef struct {
    bit v; int x; int y; int fd2; bit mask; bit done; int hit;
  } rec_t;

  rec_t   pipe[$];
  int     errors = 0;
  int     checks = 0;
  bit     m_run, m_err;
  longint m_thr;
  int     m_amb[3];
  int     m_cnt, exp_hit;
  int     hx, hy, hf, hm;

  // compensated channel difference from the plain arithmetic rules
  function automatic int cdel(input int d, input int c, input int s);
    int del, amb;
    del = (d > c) ? d - c : c - d;
    amb = s / 4;
    return (del > amb) ? del - amb : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_pix(input int dr, input int dg, input int db, input int cr,
                         input int cg, input int cb, input int ar, input int ag,
                         input int ab, input logic [31:0] thr);
    DVI_R_i = 5'(dr); DVI_G_i = 6'(dg); DVI_B_i = 5'(db);
    CCD_R_i = 5'(cr); CCD_G_i = 6'(cg); CCD_B_i = 5'(cb);
    AMB_SHIFT_R_i = 8'(ar); AMB_SHIFT_G_i = 8'(ag); AMB_SHIFT_B_i = 8'(ab);
    thresh_i = thr;
  endtask

  task automatic rand_pix(input logic [31:0] thr);
    set_pix($urandom_range(31, 0), $urandom_range(63, 0), $urandom_range(31, 0),
            $urandom_range(31, 0), $urandom_range(63, 0), $urandom_range(31, 0),
            $urandom_range(80, 0), $urandom_range(80, 0), $urandom_range(80, 0), thr);
  endtask

  // model the pixel currently on the inputs, clock once, check the outputs
  task automatic step();
    rec_t r;
    bit   oor, sof;
    int   x, y;
    r = '{default: 0};
    x = int'(syncX_i);
    y = int'(syncY_i);
    oor = valid_i && (x >= W || y >= H);
    sof = valid_i && x == 0 && y == 0;
    if (oor) begin
      m_err = 1'b1;
      m_run = 1'b0;
    end else if (valid_i && (m_run || sof)) begin
      if (sof) begin
        m_run = 1'b1;
        m_thr = longint'(thresh_i);
        m_amb[0] = int'(AMB_SHIFT_R_i);
        m_amb[1] = int'(AMB_SHIFT_G_i);
        m_amb[2] = int'(AMB_SHIFT_B_i);
      end
      r.v = 1'b1; r.x = x; r.y = y;
      r.fd2 = cdel(2 * int'(DVI_R_i), 2 * int'(CCD_R_i), m_amb[0]) ** 2
            + cdel(int'(DVI_G_i), int'(CCD_G_i), m_amb[1]) ** 2
            + cdel(2 * int'(DVI_B_i), 2 * int'(CCD_B_i), m_amb[2]) ** 2;
      r.mask = longint'(r.fd2) > m_thr;
      m_cnt = sof ? int'(r.mask) : m_cnt + int'(r.mask);
      if (x == W - 1 && y == H - 1) begin
        r.done = 1'b1;
        r.hit  = m_cnt;
        m_cnt  = 0;
      end
    end
    pipe.push_back(r);
    @(posedge clk_pixl);
    #1;
    r = pipe.pop_front();
    if (r.v) begin
      hx = r.x; hy = r.y; hf = r.fd2; hm = int'(r.mask);
    end
    if (HIT_EN && r.done) exp_hit = r.hit;
    chk("valid_o", 32'(valid_o), 32'(r.v));
    chk("syncX_o", 32'(syncX_o), hx);
    chk("syncY_o", 32'(syncY_o), hy);
    chk("fd2_o", 32'(fd2_o), hf);
    chk("mask_o", 32'(mask_o), hm);
    chk("frame_done_o", 32'(frame_done_o), HIT_EN ? 32'(r.done) : 32'd0);
    chk("hit_cnt_o", 32'(hit_cnt_o), exp_hit);
    chk("err_o", 32'(err_o), 32'(m_err));
  endtask

  task automatic reset_dut();
    reset = 1'b0;
    valid_i = 1'b0;
    pipe.delete();
    for (int i = 0; i < LAT; i++) pipe.push_back('{default: 0});
    m_run = 1'b0; m_err = 1'b0; m_thr = 0; m_cnt = 0; exp_hit = 0;
    m_amb[0] = 0; m_amb[1] = 0; m_amb[2] = 0;
    hx = 0; hy = 0; hf = 0; hm = 0;
    @(posedge clk_pixl);
    #1;
    chk("rst_valid_o", 32'(valid_o), 32'd0);
    chk("rst_sync", 32'({syncX_o, syncY_o}), 32'd0);
    chk("rst_fd2_mask", 32'({fd2_o, mask_o}), 32'd0);
    chk("rst_hit_done", 32'({hit_cnt_o, frame_done_o}), 32'd0);
    chk("rst_err_o", 32'(err_o), 32'd0);
    reset = 1'b1;
  endtask

  // one frame in raster order with random bubbles; optional out-of-range
  // pixel at index err_at, optional early stop at index stop_at
  task automatic frame(input bit pat, input logic [31:0] thr, input int err_at,
                       input int ex, input int ey, input int stop_at);
    int p;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        p = y * W + x;
        if (p == stop_at) return;
        if (p != 0 && $urandom_range(7, 0) == 0) begin
          valid_i = 1'b0;
          syncX_i = 10'($urandom);
          syncY_i = 10'($urandom);
          step();
        end
        valid_i = 1'b1;
        syncX_i = (p == err_at) ? 10'(ex) : 10'(x);
        syncY_i = (p == err_at) ? 10'(ey) : 10'(y);
        if (pat) set_pix(0, (p % 5 == 0) ? 40 : 7, 0, 0, 7, 0, 0, 0, 0, thr);
        else     rand_pix(thr);
        if (p != 0) thresh_i = $urandom;
        step();
      end
    end
  endtask

  initial begin
    reset_dut();
    // no frame start yet: (5,0) and (6,0) are dropped
    valid_i = 1'b1; syncY_i = 10'd0;
    syncX_i = 10'd5; rand_pix(32'd0); step();
    syncX_i = 10'd6; rand_pix(32'd0); step();
    valid_i = 1'b0; step();
    // directed pixels, each a frame start so its parameters get latched
    valid_i = 1'b1; syncX_i = 10'd0; syncY_i = 10'd0;
    set_pix(10, 20, 10, 10, 20, 10, 0, 0, 0, 32'd0);   step();
    set_pix(0, 40, 0, 0, 0, 0, 0, 40, 0, 32'd899);      step();
    set_pix(0, 40, 0, 0, 0, 0, 0, 40, 0, 32'd900);      step();
    set_pix(3, 0, 0, 0, 0, 0, 100, 0, 0, 32'd0);        step();
    // mid-frame threshold change must be ignored
    syncX_i = 10'd1;
    set_pix(0, 63, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF); step();
    // whole frames, back to back with different thresholds
    frame(1'b0, 32'd1500, -1, 0, 0, -1);
    frame(1'b0, 32'd300, -1, 0, 0, -1);
    frame(1'b1, 32'd1000, -1, 0, 0, -1);
    // out-of-range x mid-frame, then a clean frame
    frame(1'b0, 32'd800, 20, 700, 1, -1);
    frame(1'b0, 32'd800, -1, 0, 0, -1);
    // boundary: y equal to the frame height
    frame(1'b0, 32'd500, 40, 3, H, -1);
    frame(1'b0, 32'd2000, -1, 0, 0, -1);
    // reset in the middle of a frame
    frame(1'b0, 32'd2000, -1, 0, 0, 30);
    reset_dut();
    frame(1'b0, 32'd1200, -1, 0, 0, -1);
    frame(1'b1, 32'd0, -1, 0, 0, -1);
    valid_i = 1'b0;
    for (int i = 0; i < LAT + 2; i++) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
